// File: rtl/prmcu_uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
package prmcu_uart_pkg;

  // Frame sequencer states.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  // Parity selection, encoded exactly as the parity_mode_i input.
  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2,
    PAR_MARK = 2'd3
  } parity_t;

  localparam int MIN_DATA_BITS = 5;
  localparam int MAX_STOP_BITS = 2;

  // Data bits per frame, forced into MIN_DATA_BITS..max_bits.
  function automatic logic [3:0] clamp_data_bits(input logic [3:0] n,
                                                 input logic [3:0] max_bits);
    if (n < 4'(MIN_DATA_BITS)) begin
      return 4'(MIN_DATA_BITS);
    end else if (n > max_bits) begin
      return max_bits;
    end else begin
      return n;
    end
  endfunction

  // Stop bits per frame: zero means one, anything above the maximum means two.
  function automatic logic [1:0] clamp_stop_bits(input logic [1:0] n);
    if (n == 2'd0) begin
      return 2'd1;
    end else if (n > 2'(MAX_STOP_BITS)) begin
      return 2'(MAX_STOP_BITS);
    end else begin
      return n;
    end
  endfunction

endpackage : prmcu_uart_pkg

// File: rtl/prmcu_sync_fifo.sv
// Single-clock FIFO with show-ahead head word, one-cycle flush and occupancy count.
module prmcu_sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count == DEPTH_L);
  assign empty   = (count == '0);
  assign level   = count;
  assign rd_data = mem[rd_ptr];

  // A write coincident with flush is dropped; reads from an empty FIFO never happen.
  assign do_wr = wr_en && !full && !flush;
  assign do_rd = rd_en && !empty;

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array write port.
  // NOTE: the storage array has no reset; count/pointers alone define which words are valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule : prmcu_sync_fifo

// File: rtl/prmcu_uart_tx_buffered.sv
// FIFO-buffered UART transmitter: configurable data bits, parity, stop bits and baud divider.
module prmcu_uart_tx_buffered
  import prmcu_uart_pkg::*;
#(
  parameter int DATA_W     = 9,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tx_en_i,
  input  logic                          flush_i,
  input  logic [3:0]                    n_data_bits_i,
  input  logic [1:0]                    parity_mode_i,
  input  logic [1:0]                    n_stop_bits_i,
  input  logic [DIV_W-1:0]              clk_divider_i,
  input  logic [DATA_W-1:0]             in_dat_i,
  input  logic                          in_vld_i,
  output logic                          in_rdy_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          busy_o,
  output logic                          tx_o
);

  localparam logic [3:0] MAX_BITS = 4'(DATA_W);

  // FIFO interface
  logic [DATA_W-1:0] head_data;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;

  // Sequencer state and per-frame latched configuration
  uart_state_t       state_q;
  uart_state_t       state_d;
  logic [DATA_W-1:0] shreg_q;
  logic [3:0]        nbits_q;
  logic [1:0]        nstop_q;
  parity_t           pmode_q;
  logic [DIV_W-1:0]  div_q;
  logic [DIV_W-1:0]  div_cnt_q;
  logic [3:0]        bit_cnt_q;
  logic              par_acc_q;
  logic              tx_q;
  logic              tx_d;
  logic              par_bit;

  // Derived strobes
  logic tick;
  logic last_data;
  logic last_stop;
  logic can_start;

  prmcu_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush_i),
    .wr_en   (in_vld_i),
    .wr_data (in_dat_i),
    .rd_en   (pop),
    .rd_data (head_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level_o)
  );

  assign in_rdy_o  = !fifo_full;
  assign busy_o    = (state_q != IDLE);
  assign tx_o      = tx_q;

  assign tick      = (div_cnt_q == div_q);
  assign last_data = (bit_cnt_q == nbits_q - 4'd1);
  assign last_stop = (bit_cnt_q == {2'b00, nstop_q} - 4'd1);
  assign can_start = tx_en_i && !fifo_empty;

  // State register and registered serial line (line lags state by one cycle).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
    end
  end

  // Next-state logic; pop fires on every edge that begins a new frame.
  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (can_start) begin
          state_d = START;
          pop     = 1'b1;
        end
      end
      START: begin
        if (tick) state_d = DATA;
      end
      DATA: begin
        if (tick && last_data) state_d = (pmode_q == PAR_NONE) ? STOP : PARITY;
      end
      PARITY: begin
        if (tick) state_d = STOP;
      end
      STOP: begin
        if (tick && last_stop) begin
          if (can_start) begin
            state_d = START;
            pop     = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level for the current state.
  always_comb begin
    case (pmode_q)
      PAR_EVEN: par_bit = par_acc_q;
      PAR_ODD:  par_bit = ~par_acc_q;
      default:  par_bit = 1'b1;
    endcase
    case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_q[0];
      PARITY:  tx_d = par_bit;
      default: tx_d = 1'b1;
    endcase
  end

  // Datapath: config latch on pop, baud divider, shifter, bit counter, running parity.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q   <= '0;
      nbits_q   <= 4'(MIN_DATA_BITS);
      nstop_q   <= 2'd1;
      pmode_q   <= PAR_NONE;
      div_q     <= '0;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      par_acc_q <= 1'b0;
    end else if (pop) begin
      shreg_q   <= head_data;
      nbits_q   <= clamp_data_bits(n_data_bits_i, MAX_BITS);
      nstop_q   <= clamp_stop_bits(n_stop_bits_i);
      pmode_q   <= parity_t'(parity_mode_i);
      div_q     <= clk_divider_i;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      par_acc_q <= 1'b0;
    end else if (state_q != IDLE) begin
      div_cnt_q <= tick ? '0 : div_cnt_q + DIV_W'(1);
      if (tick) begin
        case (state_q)
          DATA: begin
            shreg_q   <= shreg_q >> 1;
            par_acc_q <= par_acc_q ^ shreg_q[0];
            bit_cnt_q <= last_data ? 4'd0 : bit_cnt_q + 4'd1;
          end
          STOP: begin
            bit_cnt_q <= last_stop ? 4'd0 : bit_cnt_q + 4'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule : prmcu_uart_tx_buffered

// File: tb/tb_prmcu_uart_tx_buffered.sv
// Self-checking bench: tx_o is compared cycle by cycle against a waveform built
// from frame rules (start, LSB-first data, parity, stop bits, divider+1 cycles each).
module tb_prmcu_uart_tx_buffered;

  localparam int DATA_W     = 9;
  localparam int FIFO_DEPTH = 8;
  localparam int DIV_W      = 16;
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              tx_en = 1'b0;
  logic              flush = 1'b0;
  logic [3:0]        n_data_bits = 4'd8;
  logic [1:0]        parity_mode = 2'd0;
  logic [1:0]        n_stop_bits = 2'd1;
  logic [DIV_W-1:0]  clk_divider = '0;
  logic [DATA_W-1:0] in_dat = '0;
  logic              in_vld = 1'b0;
  logic              in_rdy;
  logic [LVL_W-1:0]  level;
  logic              busy;
  logic              tx;

  int   total = 0;
  int   bad   = 0;
  bit   exp_q[$];
  logic got_q[$];

  always #5 clk = ~clk;

  prmcu_uart_tx_buffered #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .DIV_W      (DIV_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .tx_en_i       (tx_en),
    .flush_i       (flush),
    .n_data_bits_i (n_data_bits),
    .parity_mode_i (parity_mode),
    .n_stop_bits_i (n_stop_bits),
    .clk_divider_i (clk_divider),
    .in_dat_i      (in_dat),
    .in_vld_i      (in_vld),
    .in_rdy_o      (in_rdy),
    .level_o       (level),
    .busy_o        (busy),
    .tx_o          (tx)
  );

  // ---------------- reference model ----------------
  task automatic add_bit(input bit b, input int dv);
    repeat (dv + 1) exp_q.push_back(b);
  endtask

  task automatic add_idle(input int n);
    repeat (n) exp_q.push_back(1'b1);
  endtask

  task automatic add_frame(input int data, input int nb_raw, input int pm,
                           input int ns_raw, input int dv);
    int nb;
    int ns;
    int ones;
    bit b;
    nb   = (nb_raw < 5) ? 5 : ((nb_raw > DATA_W) ? DATA_W : nb_raw);
    ns   = (ns_raw == 0) ? 1 : ((ns_raw == 3) ? 2 : ns_raw);
    ones = 0;
    add_bit(1'b0, dv);
    for (int i = 0; i < nb; i++) begin
      b = bit'((data >> i) & 1);
      ones += int'(b);
      add_bit(b, dv);
    end
    if (pm == 1) add_bit(bit'(ones % 2), dv);
    if (pm == 2) add_bit(bit'(1 - ones % 2), dv);
    if (pm == 3) add_bit(1'b1, dv);
    repeat (ns) add_bit(1'b1, dv);
  endtask

  function automatic int first_diff();
    if (got_q.size() != exp_q.size()) return 0;
    foreach (exp_q[i]) if (got_q[i] !== logic'(exp_q[i])) return i;
    return -1;
  endfunction

  // ---------------- stimulus helpers (start and end on a falling edge) ----------------
  task automatic set_cfg(input int nb, input int pm, input int ns, input int dv);
    n_data_bits = 4'(nb);
    parity_mode = 2'(pm);
    n_stop_bits = 2'(ns);
    clk_divider = DIV_W'(dv);
  endtask

  task automatic push(input int data);
    in_vld = 1'b1;
    in_dat = DATA_W'(data);
    @(posedge clk);
    @(negedge clk);
    in_vld = 1'b0;
  endtask

  task automatic capture(input int n);
    got_q.delete();
    repeat (n) begin
      @(negedge clk);
      got_q.push_back(tx);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int d;
    rst    = 1'b1;
    in_vld = 1'b1;
    in_dat = 9'h155;
    tx_en  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset tx_o: got %b required 1", tx); end
      total++; if (in_rdy !== 1'b1) begin bad++; $display("FAIL reset in_rdy_o: got %b required 1", in_rdy); end
      total++; if (level !== '0) begin bad++; $display("FAIL reset level_o: got %0d required 0", level); end
    end
    rst    = 1'b0;
    in_vld = 1'b0;
    add_idle(8);
    capture(8);
    d = first_diff();
    total++; if (d >= 0) begin bad++; $display("FAIL reset idle line: sample %0d tx_o=%b required %b", d, got_q[d], exp_q[d]); end
    exp_q.delete();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset busy_o: got %b required 0", busy); end
    total++; if (level !== '0) begin bad++; $display("FAIL reset no write: level_o=%0d required 0", level); end
  endtask

  task automatic test_single_frame();
    int d;
    set_cfg(8, 1, 1, 3);
    tx_en = 1'b1;
    push(9'h0A5);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single busy before pop: got %b required 0", busy); end
    total++; if (level !== LVL_W'(1)) begin bad++; $display("FAIL single level after write: got %0d required 1", level); end
    add_idle(1);
    add_frame(9'h0A5, 8, 1, 1, 3);
    add_idle(4);
    fork
      capture(exp_q.size());
      begin
        @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single busy after pop: got %b required 1", busy); end
        total++; if (level !== '0) begin bad++; $display("FAIL single level after pop: got %0d required 0", level); end
        repeat (6) @(negedge clk);
        set_cfg($urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 7));
      end
    join
    d = first_diff();
    total++; if (d >= 0) begin bad++; $display("FAIL single frame 0xA5: sample %0d tx_o=%b required %b", d, got_q[d], exp_q[d]); end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    int d;
    set_cfg(5, 2, 2, 0);
    tx_en = 1'b1;
    push(9'h01F);
    push(9'h000);
    add_frame(9'h01F, 5, 2, 2, 0);
    add_frame(9'h000, 5, 2, 2, 0);
    add_idle(3);
    capture(exp_q.size());
    d = first_diff();
    total++; if (d >= 0) begin bad++; $display("FAIL back_to_back: sample %0d tx_o=%b required %b", d, got_q[d], exp_q[d]); end
    exp_q.delete();
  endtask

  task automatic test_random_frames();
    int d, nb, pm, ns, dv, data;
    tx_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      nb   = $urandom_range(0, 15);
      pm   = $urandom_range(0, 3);
      ns   = $urandom_range(0, 3);
      dv   = $urandom_range(0, 3);
      data = $urandom_range(0, 511);
      set_cfg(nb, pm, ns, dv);
      push(data);
      add_idle(1);
      add_frame(data, nb, pm, ns, dv);
      add_idle(2);
      capture(exp_q.size());
      d = first_diff();
      total++; if (d >= 0) begin bad++; $display("FAIL random frame %0d (nb=%0d pm=%0d ns=%0d dv=%0d data=%0h): sample %0d tx_o=%b required %b", k, nb, pm, ns, dv, data, d, got_q[d], exp_q[d]); end
      exp_q.delete();
    end
  endtask

  task automatic test_full();
    int d, nb, pm, ns, dv, data;
    int acc_q[$];
    bit exp_rdy;
    tx_en = 1'b0;
    nb = $urandom_range(0, 15);
    pm = $urandom_range(0, 3);
    ns = $urandom_range(0, 3);
    dv = $urandom_range(0, 2);
    set_cfg(nb, pm, ns, dv);
    for (int i = 0; i < 10; i++) begin
      exp_rdy = (acc_q.size() < FIFO_DEPTH);
      total++; if (in_rdy !== logic'(exp_rdy)) begin bad++; $display("FAIL full offer %0d in_rdy_o: got %b required %b", i, in_rdy, exp_rdy); end
      data   = $urandom_range(0, 511);
      in_vld = 1'b1;
      in_dat = DATA_W'(data);
      @(posedge clk);
      if (exp_rdy) acc_q.push_back(data);
      @(negedge clk);
    end
    in_vld = 1'b0;
    total++; if (level !== LVL_W'(FIFO_DEPTH)) begin bad++; $display("FAIL full level_o: got %0d required %0d", level, FIFO_DEPTH); end
    total++; if (in_rdy !== 1'b0) begin bad++; $display("FAIL full in_rdy_o: got %b required 0", in_rdy); end
    tx_en = 1'b1;
    @(negedge clk);
    total++; if (in_rdy !== 1'b1) begin bad++; $display("FAIL full in_rdy_o after pop: got %b required 1", in_rdy); end
    total++; if (level !== LVL_W'(FIFO_DEPTH - 1)) begin bad++; $display("FAIL full level after pop: got %0d required %0d", level, FIFO_DEPTH - 1); end
    foreach (acc_q[i]) add_frame(acc_q[i], nb, pm, ns, dv);
    add_idle(3);
    capture(exp_q.size());
    d = first_diff();
    total++; if (d >= 0) begin bad++; $display("FAIL full drain order: sample %0d tx_o=%b required %b", d, got_q[d], exp_q[d]); end
    exp_q.delete();
    total++; if (level !== '0) begin bad++; $display("FAIL full drained level_o: got %0d required 0", level); end
  endtask

  task automatic test_flush_disable();
    int d;
    int w[3];
    tx_en = 1'b0;
    set_cfg(8, 0, 1, 1);
    foreach (w[i]) begin
      w[i] = $urandom_range(0, 511);
      push(w[i]);
    end
    total++; if (level !== LVL_W'(3)) begin bad++; $display("FAIL flush queued level_o: got %0d required 3", level); end
    tx_en = 1'b1;
    add_idle(1);
    add_frame(w[0], 8, 0, 1, 1);
    add_idle(20);
    fork
      capture(exp_q.size());
      begin
        repeat (8) @(negedge clk);
        flush = 1'b1;
        tx_en = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        total++; if (level !== '0) begin bad++; $display("FAIL flush level_o: got %0d required 0", level); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL flush aborted frame: busy_o=%b required 1", busy); end
      end
    join
    d = first_diff();
    total++; if (d >= 0) begin bad++; $display("FAIL flush frame intact: sample %0d tx_o=%b required %b", d, got_q[d], exp_q[d]); end
    exp_q.delete();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush final busy_o: got %b required 0", busy); end
  endtask

  task automatic test_reset_mid_frame();
    int d, w0, w1, w2, nb, pm, ns, dv;
    tx_en = 1'b0;
    set_cfg(8, 1, 1, 2);
    w0 = $urandom_range(0, 511);
    w1 = $urandom_range(0, 511);
    push(w0);
    push(w1);
    tx_en = 1'b1;
    add_idle(1);
    add_frame(w0, 8, 1, 1, 2);
    while (exp_q.size() > 29) void'(exp_q.pop_back());
    capture(exp_q.size());
    d = first_diff();
    total++; if (d >= 0) begin bad++; $display("FAIL pre-reset frame: sample %0d tx_o=%b required %b", d, got_q[d], exp_q[d]); end
    exp_q.delete();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL pre-reset busy_o: got %b required 1", busy); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL mid reset tx_o: got %b required 1", tx); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid reset busy_o: got %b required 0", busy); end
    total++; if (level !== '0) begin bad++; $display("FAIL mid reset level_o: got %0d required 0", level); end
    add_idle(6);
    capture(exp_q.size());
    d = first_diff();
    total++; if (d >= 0) begin bad++; $display("FAIL queued data not discarded: sample %0d tx_o=%b required %b", d, got_q[d], exp_q[d]); end
    exp_q.delete();
    nb = $urandom_range(0, 15);
    pm = $urandom_range(0, 3);
    ns = $urandom_range(0, 3);
    dv = $urandom_range(0, 3);
    w2 = $urandom_range(0, 511);
    set_cfg(nb, pm, ns, dv);
    push(w2);
    add_idle(1);
    add_frame(w2, nb, pm, ns, dv);
    add_idle(2);
    capture(exp_q.size());
    d = first_diff();
    total++; if (d >= 0) begin bad++; $display("FAIL post-reset frame: sample %0d tx_o=%b required %b", d, got_q[d], exp_q[d]); end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_random_frames();
    test_full();
    test_flush_disable();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_prmcu_uart_tx_buffered
